// File: rtl/regfile_write_arbiter.sv
// Arbitrates NUM_REQ writers onto one register-file write port and owns a register clear sweep.
// Build option: define RF_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic                      rf_write_enable
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wen_q, wen_d;
  logic                done_q, done_d;
  logic                found;
  logic [PTR_W-1:0]    win;
  logic                grant;

`ifdef RF_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found = 1'b1;
        win   = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W:0]   idx;

  // Search from rr_ptr upward, wrapping; idx is one bit wider so the sum never overflows.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!found && req_valid[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
  end
`endif

  assign grant     = !reset && (state_q == IDLE) && !clear_start && found;
  assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wen_d     = 1'b0;
    done_d    = 1'b0;
`ifndef RF_ARB_FIXED_PRIO_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (found) begin
          waddr_d = req_addr[int'(win)*ADDR_W +: ADDR_W];
          wdata_d = req_data[int'(win)*DATA_W +: DATA_W];
          wen_d   = 1'b1;
`ifndef RF_ARB_FIXED_PRIO_EN
          rr_ptr_d = (win == PTR_W'(NUM_REQ-1)) ? '0 : win + PTR_W'(1);
`endif
        end
      end
      CLEAR: begin
        waddr_d = clr_cnt_q;
        wdata_d = '0;
        wen_d   = 1'b1;
        if (clr_cnt_q == ADDR_W'(NUM_REGS-1)) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
          done_d    = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      done_q    <= 1'b0;
`ifndef RF_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      done_q    <= done_d;
`ifndef RF_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  assign clear_busy      = (state_q == CLEAR);
  assign clear_done      = done_q;
  assign rf_write_addr   = waddr_q;
  assign rf_write_data   = wdata_q;
  assign rf_write_enable = wen_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a cycle-level model predicts grants and sweeps,
// a monitor pops expected writes whenever the DUT asserts rf_write_enable.
module tb_regfile_write_arbiter;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NR = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            clear_start = 1'b0;
  logic            clear_busy, clear_done;
  logic [AW-1:0]   rf_write_addr;
  logic [DW-1:0]   rf_write_data;
  logic            rf_write_enable;

  regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .clear_start(clear_start), .clear_busy(clear_busy),
    .clear_done(clear_done), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  logic [DW-1:0] model_mem [16];
  logic [DW-1:0] dut_mem   [16];

  // reference model state
  int rr = 0;
  int clr_left = 0;
  bit done_m = 0;

  // requester-side pending writes
  bit            pend [N];
  logic [AW-1:0] pa   [N];
  logic [DW-1:0] pd   [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit cs);
    int win;
    int idx;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    reset = rst;
    clear_start = cs;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_addr[i*AW +: AW] = pa[i];
      req_data[i*DW +: DW] = pd[i];
    end
    #1;
    win = -1;
    if (!rst && clr_left == 0 && !cs) begin
      for (int k = 0; k < N; k++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (rr + k) % N;
`endif
        if (win < 0 && pend[idx]) win = idx;
      end
    end
    exp_rdy = (win >= 0) ? N'(1 << win) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("clear_busy", 32'(clear_busy), 32'(clr_left > 0));
    chk("clear_done", 32'(clear_done), 32'(done_m));
    if (rst) begin
      rr = 0; clr_left = 0; done_m = 0;
      exp_q.delete();
    end else if (clr_left > 0) begin
      clr_left--;
      done_m = (clr_left == 0);
    end else begin
      done_m = 0;
      if (cs) begin
        clr_left = NR;
        for (int r = 0; r < NR; r++) exp_q.push_back('{a: AW'(r), d: '0});
      end else if (win >= 0) begin
        exp_q.push_back('{a: pa[win], d: pd[win]});
        pend[win] = 0;
        rr = (win + 1) % N;
      end
    end
  endtask

  // monitor: registered outputs settle just after the rising edge
  initial begin
    wr_t w;
    forever begin
      @(posedge clk);
      #1;
      if (rf_write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write (t=%0t)",
                   rf_write_addr, rf_write_data, $time);
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", 32'(rf_write_addr), 32'(w.a));
          chk("wr_data", 32'(rf_write_data), 32'(w.d));
          model_mem[w.a] = w.d;
        end
        dut_mem[rf_write_addr] = rf_write_data;
      end
    end
  end

  initial begin
    for (int r = 0; r < 16; r++) begin model_mem[r] = '0; dut_mem[r] = '0; end
    for (int i = 0; i < N; i++) begin pend[i] = 1; pa[i] = AW'(i); pd[i] = DW'(i); end

    // reset with every requester asserting
    step(1, 0);
    step(1, 0);
    for (int i = 0; i < N; i++) pend[i] = 0;

    // single requester
    pend[0] = 1; pa[0] = 4'h5; pd[0] = 8'hA7;
    step(0, 0);
    step(0, 0);

    // all requesters contending for six cycles
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin pend[i] = 1; pa[i] = AW'(8 + i); pd[i] = DW'(16 * c + i); end
      end
      step(0, 0);
    end
    for (int i = 0; i < N; i++) pend[i] = 0;
    step(0, 0);

    // clear sweep while requester 1 waits
    pend[1] = 1; pa[1] = 4'h9; pd[1] = 8'h5C;
    step(0, 1);
    for (int c = 0; c < 19; c++) step(0, 0);

    // reset mid-sweep, then a fresh sweep
    step(0, 1);
    for (int c = 0; c < 6; c++) step(0, 0);
    step(1, 0);
    step(0, 0);
    step(0, 1);
    for (int c = 0; c < 18; c++) step(0, 0);

    // same address from requesters 0 and 2 with rr_ptr at 2
    pend[1] = 1; pa[1] = 4'h1; pd[1] = 8'h01;
    step(0, 0);
    pend[0] = 1; pa[0] = 4'h3; pd[0] = 8'h11;
    pend[2] = 1; pa[2] = 4'h3; pd[2] = 8'h22;
    step(0, 0);
    step(0, 0);
    step(0, 0);
    step(0, 0);
`ifdef RF_ARB_FIXED_PRIO_EN
    chk("reg3_readback", 32'(dut_mem[3]), 32'h22);
`else
    chk("reg3_readback", 32'(dut_mem[3]), 32'h11);
`endif

    // randomized traffic with occasional clears and resets
    for (int c = 0; c < 1500; c++) begin
      bit rst, cs;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          pa[i] = AW'($urandom);
          pd[i] = DW'($urandom);
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      cs  = ($urandom_range(0, 39) == 0);
      step(rst, cs);
    end

    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 22; c++) step(0, 0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    for (int r = 0; r < NR; r++) chk("regfile_image", 32'(dut_mem[r]), 32'(model_mem[r]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
